trap_sequencer: RTL and testbench

- Machine-mode trap entry/exit controller for the Mini-RISC-V pipeline.
- Accepts ecall and mret indications from Decode, plus a level external interrupt.
- Sequences the entry: flush pulse, pipeline drain, mepc/mcause/mstatus CSR updates, PC redirect to the handler, then releases fetch.
- Sits beside Decode and the CSR file and drives trigger_trap, which feeds the Decode flush term.

---
 rtl/trap_sequencer.sv | 143 ++++++++++++++
 tb/tb_trap_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry/exit sequencer: flush, drain, CSR save, PC redirect.
// Any cycle with dbg_i or mem_hold_i high freezes every register, strobes included.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for trap_ret / ecall / enabled irq
// DRAIN    | older instructions retiring; counter counts down to 0
// SAVE     | mepc/mcause written, MIE stacked into MPIE
// REDIRECT | PC forced to the trap handler
// RET      | PC forced to mepc, MIE restored from MPIE
module trap_sequencer #(
    parameter int ADDR_W       = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dbg_i,
    input  logic              mem_hold_i,
    input  logic              ecall_i,
    input  logic              trap_ret_i,
    input  logic              irq_i,
    input  logic              mie_i,
    input  logic [ADDR_W-1:0] epc_in_i,
    input  logic [ADDR_W-1:0] mtvec_i,
    input  logic [ADDR_W-1:0] mepc_i,
    output logic              trigger_trap_o,
    output logic              fetch_hold_o,
    output logic              mepc_we_o,
    output logic [ADDR_W-1:0] mepc_wdata_o,
    output logic              mcause_we_o,
    output logic [31:0]       mcause_wdata_o,
    output logic              mie_clear_o,
    output logic              mie_restore_o,
    output logic              redirect_valid_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        SAVE     = 3'd2,
        REDIRECT = 3'd3,
        RET      = 3'd4
    } state_t;

    localparam logic [31:0]       CAUSE_ECALL = 32'd11;
    localparam logic [31:0]       CAUSE_IRQ   = 32'h8000_000B;
    localparam logic [2:0]        DRAIN_LOAD  = 3'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ALIGN2      = {{(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0] ALIGN4      = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic [31:0]       cause_q;
    logic [ADDR_W-1:0] epc_q;

    logic              freeze_d;
    logic              take_trap_d;
    logic [ADDR_W-1:0] vec_base_d;
    logic [ADDR_W-1:0] vec_off_d;
    logic [ADDR_W-1:0] target_d;

    assign freeze_d    = dbg_i | mem_hold_i;
    assign take_trap_d = ecall_i | (irq_i & mie_i);
    assign vec_base_d  = mtvec_i & ALIGN4;
    assign vec_off_d   = {{(ADDR_W-7){1'b0}}, cause_q[4:0], 2'b00};
    // Vectored mode only offsets interrupts; exceptions always land on the base.
    assign target_d    = (mtvec_i[1:0] == 2'b01 && cause_q[31]) ? vec_base_d + vec_off_d
                                                                 : vec_base_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            cause_q          <= '0;
            epc_q            <= '0;
            trigger_trap_o   <= 1'b0;
            fetch_hold_o     <= 1'b0;
            mepc_we_o        <= 1'b0;
            mepc_wdata_o     <= '0;
            mcause_we_o      <= 1'b0;
            mcause_wdata_o   <= '0;
            mie_clear_o      <= 1'b0;
            mie_restore_o    <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_addr_o  <= '0;
            busy_o           <= 1'b0;
        end else if (!freeze_d) begin
            trigger_trap_o   <= 1'b0;
            mepc_we_o        <= 1'b0;
            mepc_wdata_o     <= '0;
            mcause_we_o      <= 1'b0;
            mcause_wdata_o   <= '0;
            mie_clear_o      <= 1'b0;
            mie_restore_o    <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_addr_o  <= '0;
            case (state_q)
                IDLE: begin
                    if (trap_ret_i) begin
                        state_q          <= RET;
                        redirect_valid_o <= 1'b1;
                        redirect_addr_o  <= mepc_i & ALIGN2;
                        mie_restore_o    <= 1'b1;
                        busy_o           <= 1'b1;
                    end else if (take_trap_d) begin
                        state_q        <= DRAIN;
                        cnt_q          <= DRAIN_LOAD;
                        cause_q        <= ecall_i ? CAUSE_ECALL : CAUSE_IRQ;
                        epc_q          <= epc_in_i;
                        trigger_trap_o <= 1'b1;
                        fetch_hold_o   <= 1'b1;
                        busy_o         <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt_q == 3'd0) begin
                        state_q        <= SAVE;
                        mepc_we_o      <= 1'b1;
                        mepc_wdata_o   <= epc_q & ALIGN2;
                        mcause_we_o    <= 1'b1;
                        mcause_wdata_o <= cause_q;
                        mie_clear_o    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                SAVE: begin
                    state_q          <= REDIRECT;
                    redirect_valid_o <= 1'b1;
                    redirect_addr_o  <= target_d;
                end
                default: begin
                    state_q      <= IDLE;
                    fetch_hold_o <= 1'b0;
                    busy_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: a queue-based schedule model checked every
// cycle, plus literal expectations on latency, CSR data and redirect targets.
module tb_trap_sequencer;
    localparam int AW = 32;
    localparam int D  = 3;

    logic          clk = 1'b0;
    logic          rst, dbg, mem_hold, ecall, trap_ret, irq, mie;
    logic [AW-1:0] epc_in, mtvec, mepc;
    logic          trigger_trap, fetch_hold, mepc_we, mcause_we;
    logic          mie_clear, mie_restore, redirect_valid, busy;
    logic [AW-1:0] mepc_wdata, redirect_addr;
    logic [31:0]   mcause_wdata;

    trap_sequencer #(.ADDR_W(AW), .DRAIN_CYCLES(D)) dut (
        .clk_i(clk), .rst_i(rst), .dbg_i(dbg), .mem_hold_i(mem_hold),
        .ecall_i(ecall), .trap_ret_i(trap_ret), .irq_i(irq), .mie_i(mie),
        .epc_in_i(epc_in), .mtvec_i(mtvec), .mepc_i(mepc),
        .trigger_trap_o(trigger_trap), .fetch_hold_o(fetch_hold),
        .mepc_we_o(mepc_we), .mepc_wdata_o(mepc_wdata),
        .mcause_we_o(mcause_we), .mcause_wdata_o(mcause_wdata),
        .mie_clear_o(mie_clear), .mie_restore_o(mie_restore),
        .redirect_valid_o(redirect_valid), .redirect_addr_o(redirect_addr),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        trig, fh, mwe;
        logic [31:0] mwd;
        logic        cwe;
        logic [31:0] cwd;
        logic        mclr, mres, rv;
        logic [31:0] ra;
        logic        busy;
    } ov_t;

    int  checks = 0;
    int  passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // Model: each accepted request expands into the list of per-cycle output
    // vectors it must produce; every unfrozen cycle consumes one entry.
    ov_t exp_q[$];
    ov_t exp_cur;
    bit  model_on = 1'b0;

    always @(posedge clk) begin
        ov_t         v;
        logic [31:0] cause, tgt, base;
        if (rst) begin
            exp_q.delete();
            exp_cur  = '0;
            model_on = 1'b1;
        end else if (model_on && !(dbg || mem_hold)) begin
            if (exp_q.size() == 0 && !exp_cur.busy) begin
                if (trap_ret) begin
                    v = '0; v.rv = 1; v.ra = mepc & ~32'h1; v.mres = 1; v.busy = 1;
                    exp_q.push_back(v);
                end else if (ecall || (irq && mie)) begin
                    cause = ecall ? 32'd11 : 32'h8000_000B;
                    base  = mtvec & ~32'h3;
                    tgt   = (mtvec[1:0] == 2'b01 && cause[31]) ? base + 32'(cause[4:0]) * 4 : base;
                    for (int i = 0; i < D; i++) begin
                        v = '0; v.trig = (i == 0); v.fh = 1; v.busy = 1;
                        exp_q.push_back(v);
                    end
                    v = '0; v.fh = 1; v.busy = 1; v.mwe = 1; v.mwd = epc_in & ~32'h1;
                    v.cwe = 1; v.cwd = cause; v.mclr = 1;
                    exp_q.push_back(v);
                    v = '0; v.fh = 1; v.busy = 1; v.rv = 1; v.ra = tgt;
                    exp_q.push_back(v);
                end
            end
            if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
            else exp_cur = '0;
        end
    end

    function automatic ov_t mask_data(input ov_t v, input ov_t r);
        ov_t m = v;
        if (!r.mwe) m.mwd = '0;
        if (!r.cwe) m.cwd = '0;
        if (!r.rv)  m.ra  = '0;
        return m;
    endfunction

    always @(negedge clk) begin
        ov_t act;
        if (model_on) begin
            act = '{trigger_trap, fetch_hold, mepc_we, mepc_wdata, mcause_we, mcause_wdata,
                    mie_clear, mie_restore, redirect_valid, redirect_addr, busy};
            checks++;
            if (mask_data(act, exp_cur) === mask_data(exp_cur, exp_cur)) passes++;
            else $display("FAIL cycle t=%0t: got %h required %h", $time,
                          mask_data(act, exp_cur), mask_data(exp_cur, exp_cur));
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic observe(input int hold_at, input int hold_len, input bit use_dbg,
                           output int lat, output int we_n, output int trig_n, output int res_n,
                           output logic [31:0] wd, output logic [31:0] cd, output logic [31:0] ra);
        lat = -1; we_n = 0; trig_n = 0; res_n = 0; wd = '0; cd = '0; ra = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin ecall = 0; trap_ret = 0; irq = 0; end
            if (n == hold_at) begin
                if (use_dbg) dbg = 1;
                else mem_hold = 1;
            end
            if (n == hold_at + hold_len) begin dbg = 0; mem_hold = 0; end
            if (trigger_trap) trig_n++;
            if (mie_restore) res_n++;
            if (mepc_we) begin we_n++; wd = mepc_wdata; cd = mcause_wdata; end
            if (redirect_valid) begin lat = n; ra = redirect_addr; break; end
        end
    endtask

    int          lat, we_n, trig_n, res_n, rv_n;
    logic [31:0] wd, cd, ra;

    initial begin
        rst = 1; dbg = 0; mem_hold = 0; ecall = 0; trap_ret = 0; irq = 1; mie = 1;
        epc_in = '0; mtvec = 32'h200; mepc = '0;
        @(negedge clk); @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_strobes", 32'({trigger_trap, fetch_hold, mepc_we, mcause_we, mie_clear,
                                  mie_restore, redirect_valid}), 0);
        chk("reset_data", mepc_wdata | mcause_wdata | redirect_addr, 0);
        rst = 0;
        @(negedge clk);
        chk("irq_after_reset_trig", 32'(trigger_trap), 1);
        irq = 0;
        wait_idle();

        // ecall, direct mode; then a back-to-back accept right after REDIRECT
        epc_in = 32'h124; mtvec = 32'h200; ecall = 1;
        observe(0, 0, 0, lat, we_n, trig_n, res_n, wd, cd, ra);
        chk("ecall_latency", lat, 5);
        chk("ecall_mepc", wd, 32'h124);
        chk("ecall_mcause", cd, 32'd11);
        chk("ecall_target", ra, 32'h200);
        chk("ecall_trig_cnt", trig_n, 1);
        @(negedge clk);
        chk("b2b_idle", 32'(busy), 0);

        irq = 1; mie = 1; mtvec = 32'h301; epc_in = 32'h450;
        observe(0, 0, 0, lat, we_n, trig_n, res_n, wd, cd, ra);
        chk("irq_latency", lat, 5);
        chk("irq_mcause", cd, 32'h8000_000B);
        chk("irq_target", ra, 32'h32C);
        chk("irq_mepc", wd, 32'h450);
        wait_idle();

        irq = 1; mie = 0;
        repeat (6) @(negedge clk);
        chk("masked_irq_busy", 32'(busy), 0);
        irq = 0; mie = 1;

        mepc = 32'h125; trap_ret = 1; ecall = 1; irq = 1;
        observe(0, 0, 0, lat, we_n, trig_n, res_n, wd, cd, ra);
        chk("ret_latency", lat, 1);
        chk("ret_target", ra, 32'h124);
        chk("ret_restore", res_n, 1);
        chk("ret_no_trig", trig_n, 0);
        chk("ret_no_mepc_we", we_n, 0);
        wait_idle();

        mtvec = 32'h200; epc_in = 32'h124; ecall = 1;
        observe(2, 4, 0, lat, we_n, trig_n, res_n, wd, cd, ra);
        chk("stall_latency", lat, 9);
        chk("stall_we_cnt", we_n, 1);
        chk("stall_trig_cnt", trig_n, 1);
        wait_idle();

        // dbg freeze during SAVE repeats the write strobe; ecall ignores vectored mode
        mtvec = 32'h301; epc_in = 32'h127; ecall = 1;
        observe(4, 1, 1, lat, we_n, trig_n, res_n, wd, cd, ra);
        chk("dbg_latency", lat, 6);
        chk("dbg_we_cnt", we_n, 2);
        chk("dbg_mepc_bit0", wd, 32'h126);
        chk("dbg_ecall_target", ra, 32'h300);
        wait_idle();

        mtvec = 32'hFFFF_FFFD; epc_in = 32'h88; irq = 1; mie = 1;
        observe(0, 0, 0, lat, we_n, trig_n, res_n, wd, cd, ra);
        chk("wrap_target", ra, 32'h28);
        wait_idle();

        mtvec = 32'h200; epc_in = 32'h124; ecall = 1;
        @(negedge clk);
        ecall = 0;
        for (int i = 0; i < 10; i++) begin
            if (mepc_we) break;
            @(negedge clk);
        end
        chk("rst_save_reached", 32'(mepc_we), 1);
        rst = 1;
        @(negedge clk);
        chk("rst_save_we", 32'(mepc_we), 0);
        chk("rst_save_busy", 32'(busy), 0);
        rst = 0;
        rv_n = 0;
        repeat (4) begin
            if (redirect_valid) rv_n++;
            @(negedge clk);
        end
        chk("rst_save_no_redirect", rv_n, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1);
    end
endmodule
